// File: rtl/edge_irq_ctrl_if.sv
// Pin-side and register-side signal bundle of the edge interrupt controller.
// The master drives pins, configuration and clear strobes; the slave is the controller.
interface edge_irq_ctrl_if #(
  parameter int CHANNELS  = 4,
  parameter int FLT_WIDTH = 8
);
  logic [CHANNELS-1:0]  dat_i;
  logic [CHANNELS-1:0]  en_i;
  logic [CHANNELS-1:0]  re_en_i;
  logic [CHANNELS-1:0]  fe_en_i;
  logic [FLT_WIDTH-1:0] flt_cnt_i;
  logic [CHANNELS-1:0]  clr_i;
  logic [CHANNELS-1:0]  dat_o;
  logic [CHANNELS-1:0]  pend_o;
  logic [CHANNELS-1:0]  ovf_o;
  logic                 irq_o;

  modport master (
    output dat_i, en_i, re_en_i, fe_en_i, flt_cnt_i, clr_i,
    input  dat_o, pend_o, ovf_o, irq_o
  );

  modport slave (
    input  dat_i, en_i, re_en_i, fe_en_i, flt_cnt_i, clr_i,
    output dat_o, pend_o, ovf_o, irq_o
  );
endinterface

// File: rtl/edge_irq_ctrl.sv
// Multi-channel edge interrupt controller: pin synchronizer, consecutive-cycle
// glitch filter, rise/fall event select, sticky pending and overflow flags.
module edge_irq_ctrl #(
  parameter int CHANNELS  = 4,
  parameter int STAGE     = 2,
  parameter int FLT_WIDTH = 8
) (
  input  logic           clk_i,
  input  logic           rst_n_i,
  edge_irq_ctrl_if.slave bus
);

  typedef enum logic {
    ST_STABLE = 1'b0,
    ST_CHECK  = 1'b1
  } flt_state_e;

  localparam logic [FLT_WIDTH-1:0] CNT_ONE = {{(FLT_WIDTH-1){1'b0}}, 1'b1};

  logic [CHANNELS-1:0]  sync_r [STAGE];
  logic [CHANNELS-1:0]  lvl_s;
  flt_state_e           state_r     [CHANNELS];
  flt_state_e           state_nxt_s [CHANNELS];
  logic [FLT_WIDTH-1:0] cnt_r       [CHANNELS];
  logic [FLT_WIDTH-1:0] cnt_nxt_s   [CHANNELS];
  logic [FLT_WIDTH-1:0] thr_m1_s;
  logic [CHANNELS-1:0]  upd_s;
  logic [CHANNELS-1:0]  hit_s;
  logic [CHANNELS-1:0]  dat_r, pend_r, ovf_r;
  logic [CHANNELS-1:0]  dat_nxt_s, pend_nxt_s, ovf_nxt_s;

  // Synchronizer chain bringing the async pins into the clk_i domain.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int k = 0; k < STAGE; k++) begin
        sync_r[k] <= '0;
      end
    end else begin
      sync_r[0] <= bus.dat_i;
      for (int k = 1; k < STAGE; k++) begin
        sync_r[k] <= sync_r[k-1];
      end
    end
  end

  assign lvl_s = sync_r[STAGE-1];

  // Acceptance threshold minus one; a programmed 0 behaves like 1.
  always_comb begin
    if (bus.flt_cnt_i == {FLT_WIDTH{1'b0}}) begin
      thr_m1_s = {FLT_WIDTH{1'b0}};
    end else begin
      thr_m1_s = bus.flt_cnt_i - CNT_ONE;
    end
  end

  // Filter next-state: count consecutive mismatches, accept at the threshold.
  // The >= compare lets a lowered threshold take effect on the next mismatch.
  always_comb begin
    for (int i = 0; i < CHANNELS; i++) begin
      state_nxt_s[i] = ST_STABLE;
      cnt_nxt_s[i]   = {FLT_WIDTH{1'b0}};
      upd_s[i]       = 1'b0;
      case (state_r[i])
        ST_STABLE, ST_CHECK: begin
          if (lvl_s[i] != dat_r[i]) begin
            if (cnt_r[i] >= thr_m1_s) begin
              upd_s[i] = 1'b1;
            end else begin
              state_nxt_s[i] = ST_CHECK;
              cnt_nxt_s[i]   = cnt_r[i] + CNT_ONE;
            end
          end else begin
            state_nxt_s[i] = ST_STABLE;
          end
        end
        default: begin
          state_nxt_s[i] = ST_STABLE;
        end
      endcase
    end
  end

  // Filter state and counter registers.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int i = 0; i < CHANNELS; i++) begin
        state_r[i] <= ST_STABLE;
        cnt_r[i]   <= {FLT_WIDTH{1'b0}};
      end
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        state_r[i] <= state_nxt_s[i];
        cnt_r[i]   <= cnt_nxt_s[i];
      end
    end
  end

  // Event qualification and sticky flags; a hit beats a simultaneous clear.
  always_comb begin
    dat_nxt_s  = dat_r ^ upd_s;
    hit_s      = bus.en_i & ((upd_s & lvl_s & bus.re_en_i) |
                             (upd_s & ~lvl_s & bus.fe_en_i));
    pend_nxt_s = hit_s | (pend_r & ~bus.clr_i);
    ovf_nxt_s  = (hit_s & pend_r) | (ovf_r & ~bus.clr_i);
  end

  // Filtered level, pending and overflow registers.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      dat_r  <= {CHANNELS{1'b0}};
      pend_r <= {CHANNELS{1'b0}};
      ovf_r  <= {CHANNELS{1'b0}};
    end else begin
      dat_r  <= dat_nxt_s;
      pend_r <= pend_nxt_s;
      ovf_r  <= ovf_nxt_s;
    end
  end

  assign bus.dat_o  = dat_r;
  assign bus.pend_o = pend_r;
  assign bus.ovf_o  = ovf_r;
  assign bus.irq_o  = |pend_r;

endmodule

// File: tb/tb_edge_irq_ctrl.sv
// Directed bench for edge_irq_ctrl: reset, filter latency, glitch rejection,
// set-over-clear collision, enable gating, both-edge events and mid-filter reset.
module tb_edge_irq_ctrl;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  edge_irq_ctrl_if #(.CHANNELS(4), .FLT_WIDTH(8)) irq_bus ();

  edge_irq_ctrl #(.CHANNELS(4), .STAGE(2), .FLT_WIDTH(8)) dut (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .bus     (irq_bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance n rising edges, then settle 1 time unit past the edge.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [3:0] d, input logic [3:0] p,
                         input logic [3:0] o, input logic i);
    chk({tag, ".dat"},  {28'd0, irq_bus.dat_o},  {28'd0, d});
    chk({tag, ".pend"}, {28'd0, irq_bus.pend_o}, {28'd0, p});
    chk({tag, ".ovf"},  {28'd0, irq_bus.ovf_o},  {28'd0, o});
    chk({tag, ".irq"},  {31'd0, irq_bus.irq_o},  {31'd0, i});
  endtask

  task automatic clear_all();
    irq_bus.clr_i = 4'hF;
    tick(1);
    irq_bus.clr_i = 4'h0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    irq_bus.dat_i     = 4'hF;
    irq_bus.en_i      = 4'hF;
    irq_bus.re_en_i   = 4'hF;
    irq_bus.fe_en_i   = 4'h0;
    irq_bus.flt_cnt_i = 8'd3;
    irq_bus.clr_i     = 4'h0;

    // 1: reset with pins high, then rising event on all channels at edge 5
    tick(3);
    chk_all("rst", 4'h0, 4'h0, 4'h0, 1'b0);
    rst_n = 1'b1;
    tick(4);
    chk_all("rst_e4", 4'h0, 4'h0, 4'h0, 1'b0);
    tick(1);
    chk_all("rst_e5", 4'hF, 4'hF, 4'h0, 1'b1);
    clear_all();
    chk_all("rst_clr", 4'hF, 4'h0, 4'h0, 1'b0);

    // bring all levels low without raising events
    irq_bus.en_i  = 4'h0;
    irq_bus.dat_i = 4'h0;
    tick(6);
    chk_all("low", 4'h0, 4'h0, 4'h0, 1'b0);

    // 2: rising edge on ch0, falling edge ignored
    irq_bus.en_i    = 4'hF;
    irq_bus.re_en_i = 4'h1;
    irq_bus.fe_en_i = 4'h0;
    irq_bus.dat_i   = 4'h1;
    tick(4);
    chk_all("rise_e4", 4'h0, 4'h0, 4'h0, 1'b0);
    tick(1);
    chk_all("rise_e5", 4'h1, 4'h1, 4'h0, 1'b1);
    irq_bus.dat_i = 4'h0;
    tick(5);
    chk_all("fall_ign", 4'h0, 4'h1, 4'h0, 1'b1);
    clear_all();
    chk_all("rise_clr", 4'h0, 4'h0, 4'h0, 1'b0);

    // 3: two-cycle glitch rejected at N=3, one-cycle pulse accepted at N=0
    irq_bus.re_en_i = 4'h4;
    irq_bus.dat_i   = 4'h4;
    tick(2);
    irq_bus.dat_i = 4'h0;
    tick(8);
    chk_all("glitch", 4'h0, 4'h0, 4'h0, 1'b0);
    irq_bus.flt_cnt_i = 8'd0;
    irq_bus.dat_i     = 4'h4;
    tick(1);
    irq_bus.dat_i = 4'h0;
    tick(2);
    chk_all("n0_acc", 4'h4, 4'h4, 4'h0, 1'b1);
    tick(3);
    chk_all("n0_back", 4'h0, 4'h4, 4'h0, 1'b1);
    clear_all();
    irq_bus.flt_cnt_i = 8'd3;

    // 4: hit and clear in the same cycle on ch1 -> set wins, overflow flagged
    irq_bus.re_en_i = 4'h2;
    irq_bus.dat_i   = 4'h2;
    tick(5);
    chk_all("col_p", 4'h2, 4'h2, 4'h0, 1'b1);
    irq_bus.dat_i = 4'h0;
    tick(5);
    irq_bus.dat_i = 4'h2;
    tick(4);
    irq_bus.clr_i = 4'h2;
    tick(1);
    irq_bus.clr_i = 4'h0;
    chk_all("col_hit", 4'h2, 4'h2, 4'h2, 1'b1);
    irq_bus.clr_i = 4'h2;
    tick(1);
    irq_bus.clr_i = 4'h0;
    chk_all("col_clr", 4'h2, 4'h0, 4'h0, 1'b0);

    // 5: ch3 disabled tracks level only; then both edges enabled
    irq_bus.dat_i = 4'h0;
    tick(6);
    irq_bus.en_i    = 4'h7;
    irq_bus.re_en_i = 4'hF;
    irq_bus.fe_en_i = 4'hF;
    irq_bus.dat_i   = 4'h8;
    tick(5);
    chk_all("dis_hi", 4'h8, 4'h0, 4'h0, 1'b0);
    irq_bus.dat_i = 4'h0;
    tick(5);
    chk_all("dis_lo", 4'h0, 4'h0, 4'h0, 1'b0);
    irq_bus.en_i  = 4'hF;
    irq_bus.dat_i = 4'h8;
    tick(5);
    chk_all("both_r", 4'h8, 4'h8, 4'h0, 1'b1);
    irq_bus.dat_i = 4'h0;
    tick(5);
    chk_all("both_f", 4'h0, 4'h8, 4'h8, 1'b1);

    // 6: reset while ch0 is mid-filter, release with pin high
    irq_bus.fe_en_i = 4'h0;
    irq_bus.dat_i   = 4'h1;
    tick(3);
    rst_n = 1'b0;
    #1;
    chk_all("rst_mid", 4'h0, 4'h0, 4'h0, 1'b0);
    tick(2);
    rst_n = 1'b1;
    tick(4);
    chk_all("rel_e4", 4'h0, 4'h0, 4'h0, 1'b0);
    tick(1);
    chk_all("rel_e5", 4'h1, 4'h1, 4'h0, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
